// File: rtl/seg7_pkg.sv
// -----------------------------------------------------------------------------
// seg7_pkg
// Shared definitions for the multiplexed 4-digit seven-segment display link.
//   - Active-low segment codes for hex digits 0..F, z[6:0] = {a,b,c,d,e,f,g}
//   - SEG_BLANK: all segments dark
//   - NUM_DIGITS: number of multiplexed digits
//   - state_t: receive-side frame assembly FSM states
//   - seg_encode(): nibble -> active-low segment code (transmit-side helper)
// -----------------------------------------------------------------------------
package seg7_pkg;

   localparam int NUM_DIGITS = 4;

   localparam logic [6:0] SEG_0     = 7'h01;
   localparam logic [6:0] SEG_1     = 7'h4F;
   localparam logic [6:0] SEG_2     = 7'h12;
   localparam logic [6:0] SEG_3     = 7'h06;
   localparam logic [6:0] SEG_4     = 7'h4C;
   localparam logic [6:0] SEG_5     = 7'h24;
   localparam logic [6:0] SEG_6     = 7'h20;
   localparam logic [6:0] SEG_7     = 7'h0F;
   localparam logic [6:0] SEG_8     = 7'h00;
   localparam logic [6:0] SEG_9     = 7'h04;
   localparam logic [6:0] SEG_A     = 7'h08;
   localparam logic [6:0] SEG_B     = 7'h60;
   localparam logic [6:0] SEG_C     = 7'h31;
   localparam logic [6:0] SEG_D     = 7'h42;
   localparam logic [6:0] SEG_E     = 7'h30;
   localparam logic [6:0] SEG_F     = 7'h38;
   localparam logic [6:0] SEG_BLANK = 7'h7F;

   typedef enum logic {
      COLLECT = 1'b0,
      PUBLISH = 1'b1
   } state_t;

   function automatic logic [6:0] seg_encode(input logic [3:0] nib);
      logic [6:0] s;
      case (nib)
         4'h0:    s = SEG_0;
         4'h1:    s = SEG_1;
         4'h2:    s = SEG_2;
         4'h3:    s = SEG_3;
         4'h4:    s = SEG_4;
         4'h5:    s = SEG_5;
         4'h6:    s = SEG_6;
         4'h7:    s = SEG_7;
         4'h8:    s = SEG_8;
         4'h9:    s = SEG_9;
         4'hA:    s = SEG_A;
         4'hB:    s = SEG_B;
         4'hC:    s = SEG_C;
         4'hD:    s = SEG_D;
         4'hE:    s = SEG_E;
         default: s = SEG_F;
      endcase
      return s;
   endfunction

endpackage

// File: rtl/seg7_pattern_decode.sv
// -----------------------------------------------------------------------------
// seg7_pattern_decode
// Combinational decode of one active-low seven-segment pattern.
// Ports:
//   seg     in  7  active-low segments {a,b,c,d,e,f,g}
//   nibble  out 4  decoded hex digit (0 for blank or illegal patterns)
//   blank   out 1  all segments dark
//   illegal out 1  pattern is neither a hex glyph nor blank
// -----------------------------------------------------------------------------
module seg7_pattern_decode
   import seg7_pkg::*;
(
   input  logic [6:0] seg,
   output logic [3:0] nibble,
   output logic       blank,
   output logic       illegal
);

   always_comb begin
      nibble  = 4'h0;
      blank   = 1'b0;
      illegal = 1'b0;
      case (seg)
         SEG_0:     nibble = 4'h0;
         SEG_1:     nibble = 4'h1;
         SEG_2:     nibble = 4'h2;
         SEG_3:     nibble = 4'h3;
         SEG_4:     nibble = 4'h4;
         SEG_5:     nibble = 4'h5;
         SEG_6:     nibble = 4'h6;
         SEG_7:     nibble = 4'h7;
         SEG_8:     nibble = 4'h8;
         SEG_9:     nibble = 4'h9;
         SEG_A:     nibble = 4'hA;
         SEG_B:     nibble = 4'hB;
         SEG_C:     nibble = 4'hC;
         SEG_D:     nibble = 4'hD;
         SEG_E:     nibble = 4'hE;
         SEG_F:     nibble = 4'hF;
         SEG_BLANK: blank  = 1'b1;
         default:   illegal = 1'b1;
      endcase
   end

endmodule

// File: rtl/seg7_scan_decoder.sv
// -----------------------------------------------------------------------------
// seg7_scan_decoder
// Receive side of a multiplexed 4-digit seven-segment display. Watches the
// active-low digit selects and segment lines, samples each digit once per
// stable dwell, and publishes the four reconstructed digits as one word.
// Parameters:
//   SETTLE  cycles a one-hot-low select must be stable before sampling (>=1)
//   TIMEOUT cycles without a capture before a partial frame is discarded
// Ports:
//   clk         in  1   system clock
//   clr         in  1   asynchronous active-low reset
//   x           in  4   digit select, active-low (x[i]=0 selects digit i)
//   z           in  7   segments, active-low {a,b,c,d,e,f,g}
//   value       out 16  decoded digits, digit i in value[4i+3:4i]
//   blank       out 4   per-digit blank flag
//   frame_valid out 1   one-cycle pulse, value/blank are new in this cycle
//   err         out 1   sticky: an illegal segment pattern was captured
//   stale       out 1   sticky: a partial frame was dropped on timeout
// -----------------------------------------------------------------------------
module seg7_scan_decoder
   import seg7_pkg::*;
#(
   parameter int SETTLE  = 4,
   parameter int TIMEOUT = 65536
)(
   input  logic        clk,
   input  logic        clr,
   input  logic [3:0]  x,
   input  logic [6:0]  z,
   output logic [15:0] value,
   output logic [3:0]  blank,
   output logic        frame_valid,
   output logic        err,
   output logic        stale
);

   localparam int SW = $clog2(SETTLE + 1);
   localparam int TW = $clog2(TIMEOUT);

   localparam logic [SW-1:0] SETTLE_MAX   = SW'(SETTLE);
   localparam logic [SW-1:0] SETTLE_ARM   = SW'(SETTLE - 1);
   localparam logic [TW-1:0] TIMEOUT_LAST = TW'(TIMEOUT - 1);

   // Input stage and settle tracking
   logic [3:0]    xr_reg, xprev_reg;
   logic [6:0]    zr_reg;
   logic [SW-1:0] settle_reg, settle_next;

   // Frame assembly
   state_t                  state_reg, state_next;
   logic [NUM_DIGITS-1:0]   seen_reg, seen_next;
   logic [TW-1:0]           tout_reg, tout_next;
   logic [4*NUM_DIGITS-1:0] shadow_val_reg, shadow_val_next;
   logic [NUM_DIGITS-1:0]   shadow_blank_reg, shadow_blank_next;
   logic [15:0]             value_reg, value_next;
   logic [3:0]              blank_reg, blank_next;
   logic                    err_reg, err_next;
   logic                    stale_reg, stale_next;

   logic [NUM_DIGITS-1:0] sel;
   logic [NUM_DIGITS-1:0] seen_hit;
   logic [NUM_DIGITS-1:0] seen_merge;
   logic                  onehot_low;
   logic                  stable;
   logic                  capture;

   logic [3:0] dec_nibble;
   logic       dec_blank;
   logic       dec_illegal;

   seg7_pattern_decode u_decode (
      .seg     (zr_reg),
      .nibble  (dec_nibble),
      .blank   (dec_blank),
      .illegal (dec_illegal)
   );

   assign sel        = ~xr_reg;
   assign onehot_low = $onehot(sel);
   assign stable     = onehot_low && (xr_reg == xprev_reg);

   // Counter saturates so a long dwell strobes only once, on the
   // SETTLE-1 -> SETTLE step.
   always_comb begin
      settle_next = '0;
      if (stable) begin
         settle_next = (settle_reg == SETTLE_MAX) ? settle_reg : settle_reg + 1'b1;
      end
   end

   assign capture    = stable && (settle_reg == SETTLE_ARM);
   assign seen_hit   = capture ? sel : '0;
   assign seen_merge = seen_reg | seen_hit;

   generate
      for (genvar gi = 0; gi < NUM_DIGITS; gi++) begin : g_shadow
         assign shadow_val_next[4*gi +: 4] = seen_hit[gi] ? dec_nibble
                                                          : shadow_val_reg[4*gi +: 4];
         assign shadow_blank_next[gi]      = seen_hit[gi] ? dec_blank
                                                          : shadow_blank_reg[gi];
      end
   endgenerate

   // Frame FSM. value/blank load from the merged shadow on the completing
   // capture so they are already new during the PUBLISH cycle, where
   // frame_valid is high.
   always_comb begin
      state_next  = state_reg;
      seen_next   = seen_reg;
      tout_next   = tout_reg;
      value_next  = value_reg;
      blank_next  = blank_reg;
      stale_next  = stale_reg;
      err_next    = err_reg | (capture & dec_illegal);
      frame_valid = 1'b0;
      case (state_reg)
         COLLECT: begin
            if (capture) begin
               seen_next = seen_merge;
               tout_next = '0;
               if (&seen_merge) begin
                  state_next = PUBLISH;
                  value_next = shadow_val_next;
                  blank_next = shadow_blank_next;
               end
            end else if (seen_reg == '0) begin
               tout_next = '0;
            end else if (tout_reg == TIMEOUT_LAST) begin
               seen_next  = '0;
               stale_next = 1'b1;
               tout_next  = '0;
            end else begin
               tout_next = tout_reg + 1'b1;
            end
         end
         PUBLISH: begin
            frame_valid = 1'b1;
            state_next  = COLLECT;
            // A capture landing here (SETTLE=1, tight scan) starts the next frame.
            seen_next   = seen_hit;
            tout_next   = '0;
         end
         default: begin
            state_next = COLLECT;
            seen_next  = '0;
            tout_next  = '0;
         end
      endcase
   end

   always_ff @(posedge clk or negedge clr) begin
      if (!clr) begin
         xr_reg           <= 4'hF;
         xprev_reg        <= 4'hF;
         zr_reg           <= SEG_BLANK;
         settle_reg       <= '0;
         state_reg        <= COLLECT;
         seen_reg         <= '0;
         tout_reg         <= '0;
         shadow_val_reg   <= '0;
         shadow_blank_reg <= '0;
         value_reg        <= 16'h0000;
         blank_reg        <= 4'b1111;
         err_reg          <= 1'b0;
         stale_reg        <= 1'b0;
      end else begin
         xr_reg           <= x;
         xprev_reg        <= xr_reg;
         zr_reg           <= z;
         settle_reg       <= settle_next;
         state_reg        <= state_next;
         seen_reg         <= seen_next;
         tout_reg         <= tout_next;
         shadow_val_reg   <= shadow_val_next;
         shadow_blank_reg <= shadow_blank_next;
         value_reg        <= value_next;
         blank_reg        <= blank_next;
         err_reg          <= err_next;
         stale_reg        <= stale_next;
      end
   end

   assign value = value_reg;
   assign blank = blank_reg;
   assign err   = err_reg;
   assign stale = stale_reg;

endmodule

// File: tb/tb_seg7_scan_decoder.sv
// -----------------------------------------------------------------------------
// tb_seg7_scan_decoder
// Directed bench for seg7_scan_decoder with SETTLE=4, TIMEOUT=32.
// Inputs change on the falling edge; outputs are sampled on the falling edge.
// -----------------------------------------------------------------------------
module tb_seg7_scan_decoder;

   logic        clk;
   logic        clr;
   logic [3:0]  x;
   logic [6:0]  z;
   logic [15:0] value;
   logic [3:0]  blank;
   logic        frame_valid;
   logic        err;
   logic        stale;

   int n_cmp;
   int n_err;

   // frame_valid observations made by dwell()
   int          fv_cnt;
   int          fv_k;
   logic [3:0]  fv_x;
   logic [15:0] fv_val;
   logic [3:0]  fv_blk;

   typedef struct {
      logic [6:0]  z0, z1, z2, z3;
      logic [15:0] val;
      logic [3:0]  blk;
   } scan_vec_t;

   scan_vec_t tbl [5];

   seg7_scan_decoder #(
      .SETTLE  (4),
      .TIMEOUT (32)
   ) dut (
      .clk         (clk),
      .clr         (clr),
      .x           (x),
      .z           (z),
      .value       (value),
      .blank       (blank),
      .frame_valid (frame_valid),
      .err         (err),
      .stale       (stale)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish, got timeout required finish");
      $fatal(1);
   end

   task automatic chk(input string name, input logic [15:0] act, input logic [15:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got %h required %h", name, act, exp);
      end else begin
         $display("ok   %s: %h", name, act);
      end
   endtask

   // Present dx/dz for n cycles, sampling outputs on each falling edge.
   task automatic dwell(input logic [3:0] dx, input logic [6:0] dz, input int n);
      for (int k = 0; k < n; k++) begin
         x = dx;
         z = dz;
         @(negedge clk);
         if (frame_valid === 1'b1) begin
            fv_cnt++;
            fv_k   = k;
            fv_x   = dx;
            fv_val = value;
            fv_blk = blank;
         end
      end
   endtask

   task automatic scan4(input logic [6:0] z0, input logic [6:0] z1,
                        input logic [6:0] z2, input logic [6:0] z3);
      dwell(4'hE, z0, 8);
      dwell(4'hD, z1, 8);
      dwell(4'hB, z2, 8);
      dwell(4'h7, z3, 8);
   endtask

   initial begin
      n_cmp  = 0;
      n_err  = 0;
      fv_cnt = 0;
      fv_k   = -1;
      fv_x   = 4'h0;
      fv_val = 16'h0;
      fv_blk = 4'h0;
      clr    = 1'b0;
      x      = 4'hF;
      z      = 7'h7F;

      //                 z0     z1     z2     z3     value     blank
      tbl[0] = '{7'h4F, 7'h12, 7'h06, 7'h4C, 16'h4321, 4'b0000};
      tbl[1] = '{7'h01, 7'h24, 7'h08, 7'h31, 16'hCA50, 4'b0000};
      tbl[2] = '{7'h60, 7'h42, 7'h30, 7'h38, 16'hFEDB, 4'b0000};
      tbl[3] = '{7'h20, 7'h0F, 7'h00, 7'h04, 16'h9876, 4'b0000};
      tbl[4] = '{7'h7F, 7'h01, 7'h7F, 7'h4F, 16'h1000, 4'b0101};

      // ---- Reset held with toggling inputs ----
      for (int i = 0; i < 8; i++) begin
         x = 4'($urandom);
         z = 7'($urandom);
         @(negedge clk);
         chk($sformatf("rst%0d_value", i), value, 16'h0000);
         chk($sformatf("rst%0d_misc", i),
             {9'd0, blank, frame_valid, err, stale}, {9'd0, 4'b1111, 3'b000});
      end
      x   = 4'hF;
      z   = 7'h7F;
      clr = 1'b1;
      dwell(4'hF, 7'h7F, 3);

      // ---- Table-driven full scans ----
      for (int v = 0; v < 5; v++) begin
         fv_cnt = 0;
         scan4(tbl[v].z0, tbl[v].z1, tbl[v].z2, tbl[v].z3);
         chk($sformatf("scan%0d_fvcount", v), 16'(fv_cnt), 16'd1);
         chk($sformatf("scan%0d_fvpos", v), {8'(fv_k), 4'h0, fv_x}, {8'd5, 4'h0, 4'h7});
         chk($sformatf("scan%0d_value", v), fv_val, tbl[v].val);
         chk($sformatf("scan%0d_blank", v), {12'd0, fv_blk}, {12'd0, tbl[v].blk});
         chk($sformatf("scan%0d_flags", v), {14'd0, err, stale}, 16'd0);
      end

      // ---- Glitch dwells (3 and SETTLE cycles) do not capture ----
      fv_cnt = 0;
      dwell(4'hE, 7'h01, 8);
      dwell(4'hD, 7'h12, 8);
      dwell(4'hE, 7'h4F, 3);
      dwell(4'hB, 7'h06, 8);
      dwell(4'hE, 7'h4F, 4);
      dwell(4'h7, 7'h4C, 8);
      chk("glitch_fvcount", 16'(fv_cnt), 16'd1);
      chk("glitch_value", fv_val, 16'h4320);

      // ---- Minimum dwell of SETTLE+1 cycles captures ----
      fv_cnt = 0;
      dwell(4'hE, 7'h01, 5);
      dwell(4'hD, 7'h4F, 5);
      dwell(4'hB, 7'h12, 5);
      dwell(4'h7, 7'h06, 5);
      dwell(4'hF, 7'h7F, 4);
      chk("mindwell_fvcount", 16'(fv_cnt), 16'd1);
      chk("mindwell_value", fv_val, 16'h3210);

      // ---- Multi-select / no-select dwells leave seen untouched ----
      fv_cnt = 0;
      dwell(4'hE, 7'h01, 8);
      dwell(4'hD, 7'h4F, 8);
      dwell(4'hC, 7'h12, 20);
      chk("multisel_nofv", 16'(fv_cnt), 16'd0);
      dwell(4'hB, 7'h06, 8);
      dwell(4'h7, 7'h4C, 8);
      chk("multisel_fvcount", 16'(fv_cnt), 16'd1);
      chk("multisel_value", fv_val, 16'h4310);
      fv_cnt = 0;
      dwell(4'hE, 7'h24, 8);
      dwell(4'hD, 7'h20, 8);
      dwell(4'hF, 7'h12, 20);
      dwell(4'hB, 7'h06, 8);
      dwell(4'h7, 7'h4C, 8);
      chk("nosel_fvcount", 16'(fv_cnt), 16'd1);
      chk("nosel_value", fv_val, 16'h4365);

      // ---- Illegal and blank patterns ----
      fv_cnt = 0;
      scan4(7'h4F, 7'h7E, 7'h7F, 7'h4C);
      chk("illegal_fvcount", 16'(fv_cnt), 16'd1);
      chk("illegal_value", fv_val, 16'h4001);
      chk("illegal_blank", {12'd0, fv_blk}, {12'd0, 4'b0100});
      chk("illegal_err", {15'd0, err}, 16'd1);
      fv_cnt = 0;
      scan4(7'h4F, 7'h12, 7'h06, 7'h4C);
      chk("err_sticky", {15'd0, err}, 16'd1);
      chk("after_err_value", fv_val, 16'h4321);

      // ---- Timeout drops a partial frame ----
      fv_cnt = 0;
      dwell(4'hE, 7'h01, 8);
      dwell(4'hD, 7'h4F, 8);
      dwell(4'hF, 7'h7F, 20);
      chk("timeout_early_stale", {15'd0, stale}, 16'd0);
      dwell(4'hF, 7'h7F, 20);
      chk("timeout_stale", {15'd0, stale}, 16'd1);
      chk("timeout_nofv", 16'(fv_cnt), 16'd0);
      chk("timeout_value_kept", value, 16'h4321);
      dwell(4'hB, 7'h06, 8);
      dwell(4'h7, 7'h4C, 8);
      chk("timeout_partial_nofv", 16'(fv_cnt), 16'd0);
      dwell(4'hE, 7'h24, 8);
      dwell(4'hD, 7'h20, 8);
      chk("timeout_fresh_fvcount", 16'(fv_cnt), 16'd1);
      chk("timeout_fresh_value", fv_val, 16'h4365);
      chk("stale_sticky", {15'd0, stale}, 16'd1);

      // ---- Reset mid-scan discards captured digits ----
      fv_cnt = 0;
      dwell(4'hE, 7'h01, 8);
      dwell(4'hD, 7'h4F, 8);
      clr = 1'b0;
      #1;
      chk("midrst_value", value, 16'h0000);
      chk("midrst_misc", {9'd0, blank, frame_valid, err, stale}, {9'd0, 4'b1111, 3'b000});
      dwell(4'hF, 7'h7F, 2);
      clr = 1'b1;
      dwell(4'hB, 7'h06, 8);
      dwell(4'h7, 7'h4C, 8);
      chk("midrst_partial_nofv", 16'(fv_cnt), 16'd0);
      dwell(4'hE, 7'h12, 8);
      dwell(4'hD, 7'h06, 8);
      chk("midrst_fvcount", 16'(fv_cnt), 16'd1);
      chk("midrst_value_new", fv_val, 16'h4332);
      chk("midrst_flags", {14'd0, err, stale}, 16'd0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
